// File: rtl/bus_slave_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_port_ctrl_if
// Purpose  : Bit-serial bus bundle between a bus master and the slave port.
// Revision : 1.0
// ============================================================================
interface bus_slave_port_ctrl_if;
    logic mvalid;
    logic mwdata;
    logic mode;
    logic ready;
    logic srdata;
    logic srvalid;
    logic done;

    modport master (
        output mvalid, mwdata, mode,
        input  ready, srdata, srvalid, done
    );

    modport slave (
        input  mvalid, mwdata, mode,
        output ready, srdata, srvalid, done
    );
endinterface
`default_nettype wire

// File: rtl/bus_slave_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_port_ctrl
// Purpose  : Deserialises bit-serial bus transactions into one BRAM write or
//            read, and serialises read data back onto the bus.
// Revision : 1.0
// ============================================================================
module bus_slave_port_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    bus_slave_port_ctrl_if.slave       bus,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       mem_wen,
    output logic                       mem_ren,
    input  wire logic [DATA_WIDTH-1:0] mem_rdata,
    input  wire logic                  mem_rvalid
);

    localparam int c_MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int c_CNT_W = $clog2(c_MAX_W) + 1;
    // The first address bit is taken in IDLE, so ADDR only counts the rest.
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'((ADDR_WIDTH > 1) ? ADDR_WIDTH - 2 : 0);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_END  = c_CNT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_RSEND = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_addr_sr;
    logic [DATA_WIDTH-1:0] r_wdata_sr;
    logic [DATA_WIDTH-1:0] r_rdata_sr;
    logic [ADDR_WIDTH-1:0] w_addr_shift;
    logic [DATA_WIDTH-1:0] w_wdata_shift;
    logic                  w_ready;
    logic                  w_srvalid;
    logic                  w_done;
    logic                  w_wen;
    logic                  w_ren;
    logic                  w_cnt_inc;

    assign w_addr_shift  = (r_addr_sr  >> 1) | (ADDR_WIDTH'(bus.mwdata) << (ADDR_WIDTH - 1));
    assign w_wdata_shift = (r_wdata_sr >> 1) | (DATA_WIDTH'(bus.mwdata) << (DATA_WIDTH - 1));
    assign w_cnt_inc     = (((r_state == S_ADDR) || (r_state == S_WDATA)) && bus.mvalid)
                         || (r_state == S_RSEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_srvalid   = 1'b0;
        w_done      = 1'b0;
        w_wen       = 1'b0;
        w_ren       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.mvalid) begin
                    if (ADDR_WIDTH == 1) begin
                        w_state_nxt = bus.mode ? S_WDATA : S_READ;
                    end else begin
                        w_state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (bus.mvalid && (r_cnt == c_ADDR_LAST)) begin
                    w_state_nxt = r_mode ? S_WDATA : S_READ;
                end
            end
            S_WDATA: begin
                if (bus.mvalid && (r_cnt == c_DATA_LAST)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_wen       = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_READ: begin
                w_ren = 1'b1;
                if (mem_rvalid) begin
                    w_state_nxt = S_RSEND;
                end
            end
            S_RSEND: begin
                // One extra cycle past the last bit carries the done pulse.
                if (r_cnt == c_DATA_END) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_srvalid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_addr_sr  <= '0;
            r_wdata_sr <= '0;
            r_rdata_sr <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == S_IDLE) && bus.mvalid) begin
                r_mode <= bus.mode;
            end

            if (((r_state == S_IDLE) || (r_state == S_ADDR)) && bus.mvalid) begin
                r_addr_sr <= w_addr_shift;
                if ((w_state_nxt == S_WDATA) || (w_state_nxt == S_READ)) begin
                    mem_addr <= w_addr_shift;
                end
            end

            if ((r_state == S_WDATA) && bus.mvalid) begin
                r_wdata_sr <= w_wdata_shift;
                if (w_state_nxt == S_WRITE) begin
                    mem_wdata <= w_wdata_shift;
                end
            end

            if ((r_state == S_READ) && mem_rvalid) begin
                r_rdata_sr <= mem_rdata;
            end else if (w_srvalid) begin
                r_rdata_sr <= r_rdata_sr >> 1;
            end
        end
    end

    assign bus.ready   = w_ready;
    assign bus.srvalid = w_srvalid;
    assign bus.srdata  = w_srvalid & r_rdata_sr[0];
    assign bus.done    = w_done;
    assign mem_wen     = w_wen;
    assign mem_ren     = w_ren;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_slave_port_ctrl
// Purpose  : Randomised scoreboard bench with a BRAM model for the slave port.
// Revision : 1.0
// ============================================================================
module tb_bus_slave_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;

    bus_slave_port_ctrl_if bus();

    bus_slave_port_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    // BRAM: rvalid low on the first sampled ren cycle, high from the second.
    logic [7:0] bram [0:4095];
    logic       ren_d;
    always @(posedge clk) begin
        if (rst) begin
            ren_d      <= 1'b0;
            mem_rvalid <= 1'b0;
        end else begin
            ren_d      <= mem_ren;
            mem_rvalid <= mem_ren & ren_d;
            mem_rdata  <= bram[mem_addr];
            if (mem_wen) bram[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [0:4095];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops expected results when the DUT completes a transaction.
    initial begin
        int         ren_cnt = 0;
        int         bitidx  = 0;
        logic [7:0] acc     = '0;
        bit         chk_rdy = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                ren_cnt = 0; bitidx = 0; acc = '0; chk_rdy = 0;
            end else begin
                if (chk_rdy) begin
                    check("ready_after_done", {31'd0, bus.ready}, 32'd1);
                    chk_rdy = 0;
                end
                check("wen_ren_exclusive", {31'd0, mem_wen & mem_ren}, 32'd0);
                if (mem_ren) ren_cnt++;
                if (bus.srvalid) begin
                    if (bitidx < 8) acc[bitidx] = bus.srdata;
                    bitidx++;
                end
                if (mem_wen || bus.done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_kind_write", {31'd0, mem_wen}, {31'd0, e.wr});
                        check("done_pulse", {31'd0, bus.done}, 32'd1);
                        check("mem_addr", {20'd0, mem_addr}, {20'd0, e.addr});
                        if (e.wr) begin
                            check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
                        end else begin
                            check("srvalid_in_done", {31'd0, bus.srvalid}, 32'd0);
                            check("ren_cycles", ren_cnt, 3);
                            check("read_bits", bitidx, 8);
                            check("read_data", {24'd0, acc}, {24'd0, e.data});
                        end
                    end
                    ren_cnt = 0; bitidx = 0; acc = '0; chk_rdy = 1;
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 200; k++) begin
            if (bus.ready) break;
            @(posedge clk); #1;
        end
        if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_bits(input bit wr, input logic [11:0] a, input logic [7:0] d,
                              input int stall_at, input int stall_len);
        int nbits = wr ? 20 : 12;
        for (int i = 0; i < nbits; i++) begin
            bus.mvalid = 1'b1;
            bus.mwdata = (i < 12) ? a[i] : d[i-12];
            bus.mode   = (i == 0) ? wr : 1'($urandom);
            @(posedge clk); #1;
            if (i == stall_at && i < nbits - 1) begin
                for (int k = 0; k < stall_len; k++) begin
                    bus.mvalid = 1'b0;
                    bus.mwdata = 1'($urandom);
                    check("ready_low_in_stall", {31'd0, bus.ready}, 32'd0);
                    @(posedge clk); #1;
                end
            end
        end
        bus.mvalid = 1'b0;
    endtask

    task automatic send_txn(input bit wr, input logic [11:0] a, input logic [7:0] d,
                            input int stall_at, input int stall_len, input bit noise);
        exp_t e;
        int   k;
        wait_ready();
        e.wr = wr; e.addr = a;
        if (wr) begin
            ref_mem[a] = d;
            e.data = d;
        end else begin
            e.data = ref_mem[a];
        end
        exp_q.push_back(e);
        drive_bits(wr, a, d, stall_at, stall_len);
        // While busy, bus activity must be ignored.
        for (k = 0; k < 200; k++) begin
            if (bus.ready) break;
            if (noise) begin
                bus.mvalid = 1'($urandom);
                bus.mwdata = 1'($urandom);
                bus.mode   = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        bus.mvalid = 1'b0;
        if (!bus.ready) check("txn_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 4096; i++) begin
            bram[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bram[12'h123]    = 8'h3C;
        ref_mem[12'h123] = 8'h3C;

        rst = 1'b1; bus.mvalid = 1'b0; bus.mwdata = 1'b0; bus.mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",     {31'd0, bus.ready},   32'd1);
        check("rst_srvalid",   {31'd0, bus.srvalid}, 32'd0);
        check("rst_srdata",    {31'd0, bus.srdata},  32'd0);
        check("rst_done",      {31'd0, bus.done},    32'd0);
        check("rst_wen_ren",   {30'd0, mem_wen, mem_ren}, 32'd0);
        check("rst_mem_addr",  {20'd0, mem_addr},  32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        send_txn(1'b0, 12'h123, 8'h00, -1, 0, 1'b0);
        send_txn(1'b1, 12'h123, 8'hA5, -1, 0, 1'b0);
        send_txn(1'b1, 12'h456, 8'h69, 6, 5, 1'b0);
        send_txn(1'b0, 12'h456, 8'h00, 6, 5, 1'b0);

        // Abort a read with reset during its second mem_ren cycle.
        wait_ready();
        drive_bits(1'b0, 12'h123, 8'h00, -1, 0);
        @(posedge clk); #1;
        check("ren_before_abort", {31'd0, mem_ren}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ren",     {31'd0, mem_ren},     32'd0);
        check("abort_ready",   {31'd0, bus.ready},   32'd1);
        check("abort_srvalid", {31'd0, bus.srvalid}, 32'd0);
        check("abort_done",    {31'd0, bus.done},    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        send_txn(1'b1, 12'h7E1, 8'hC3, -1, 0, 1'b0);
        send_txn(1'b0, 12'h7E1, 8'h00, -1, 0, 1'b1);

        // Back-to-back write then read with busy noise.
        send_txn(1'b1, 12'h001, 8'h5A, -1, 0, 1'b1);
        send_txn(1'b0, 12'h001, 8'h00, -1, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [11:0] a;
            a = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 7)) : 12'($urandom);
            send_txn(1'($urandom), a, 8'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : -1,
                     int'($urandom_range(1, 4)), 1'($urandom));
        end

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_slave_port_ctrl.md
Name: bus_slave_port_ctrl

Overview:
- Slave-side bus port that sits directly upstream of the BRAM slave memory.
- Deserialises bit-serial bus transactions (address, mode, write data) into one parallel memory write or read.
- For reads, holds the memory read enable until the memory flags valid data, then serialises the read word back onto the bus.
- One clock domain; one transaction in flight at a time.

Parameters:
ADDR_WIDTH, 12, address bits shifted in per transaction; drives mem_addr
DATA_WIDTH, 8, data word width (serial write and read payload)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
mvalid  input  1  bus bit valid; mwdata is consumed only when high
mwdata  input  1  serial address/write-data bit, LSB first
mode  input  1  1=write, 0=read; sampled on the transaction's first accepted bit
ready  output  1  high only in IDLE: port accepts a new transaction
srdata  output  1  serial read-data bit, LSB first
srvalid  output  1  srdata valid
done  output  1  one-cycle pulse at transaction completion
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_wen  output  1  memory write enable
mem_ren  output  1  memory read enable (level)
mem_rdata  input  DATA_WIDTH  memory read data
mem_rvalid  input  1  memory read data valid

Behaviour:
- Reset: state=IDLE. ready=1. srdata, srvalid, done, mem_wen and mem_ren=0. mem_addr, mem_wdata and the shift registers=0. Bit counter=0.
- Reset asserted mid-transaction aborts the transaction:
  - IDLE is reached at the next edge.
  - No mem_wen pulse and no done pulse for the aborted transaction.
  - mem_ren drops at the same edge.
- FSM states: IDLE, ADDR, WDATA, WRITE, READ, RSEND.
- IDLE:
  - The first cycle with mvalid=1 takes mwdata as addr[0] and latches mode.
  - Next state is ADDR, or the end-of-address transition below if ADDR_WIDTH=1.
- ADDR:
  - Each mvalid=1 cycle shifts in the next address bit, LSB first.
  - mvalid=0 stalls: no shift, no counter change, no timeout.
  - After ADDR_WIDTH accepted bits, mem_addr is loaded.
  - Next state is WDATA if mode=1, else READ.
- WDATA:
  - Shifts in DATA_WIDTH bits, same stall rule as ADDR.
  - The edge accepting the last bit loads mem_wdata and enters WRITE.
- WRITE:
  - Exactly one cycle with mem_wen=1; mem_addr and mem_wdata are stable.
  - done=1 in the same cycle; then IDLE.
- READ:
  - mem_ren=1 every cycle in READ. mem_addr is held.
  - In the first cycle with mem_rvalid=1, mem_rdata is captured into the read shift register at that edge, and the state goes to RSEND.
  - With the team BRAM (rvalid low on the first sampled ren cycle, high on the second), mem_ren is high for exactly 3 cycles.
  - No timeout; the port waits indefinitely.
- RSEND:
  - mem_ren=0, srvalid=1 for exactly DATA_WIDTH consecutive cycles, srdata=bit i in cycle i.
  - done=1 in the cycle after the last bit; then IDLE. srvalid=0 in the done cycle.
- Outside IDLE/ADDR/WDATA, mvalid and mwdata are ignored. mode is ignored except on the first accepted bit.
- ready=0 in every state except IDLE.
- mem_wen and mem_ren are never high simultaneously.
- Bit counter width is clog2(max(ADDR_WIDTH, DATA_WIDTH))+1. It clears on every state change.
- Latency with no stalls:
  - Write: mem_wen occurs in the cycle after the final data bit is accepted.
  - Read: mem_ren rises in the cycle after the final address bit; first srvalid comes 3 cycles later.
- Back-to-back transactions: a new transaction may start in the cycle after done, when ready=1.

Test Plan:
- Write, no stalls: shift addr 0x123 then data 0xA5 with mode=1 -> mem_wen high for exactly 1 cycle with mem_addr=0x123, mem_wdata=0xA5, done coincident; ready=1 next cycle.
- Read against the BRAM model preloaded 0x3C at 0x123: mode=0, addr 0x123 -> mem_ren high for 3 cycles; srvalid for 8 cycles with srdata=0,0,1,1,1,1,0,0; done after; mem_wen never high.
- Stalled address: mvalid=0 for 5 cycles after addr bit 6 -> shift holds, final mem_addr is still correct, ready stays 0 throughout.
- Reset mid-read: assert rst during the second mem_ren cycle -> next edge mem_ren=0, ready=1, srvalid=0, no done pulse; a subsequent write succeeds.
- Busy-ignore: mvalid toggled with random mwdata during READ and RSEND -> transaction data unchanged, no second transaction started.
- Back-to-back: write 0x5A to 0x001 immediately followed by a read of 0x001 -> serial read returns 0x5A.
